// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction, scancode and parser-state definitions for snake steering
package snake_pkg;

   localparam logic [2:0] DIR_RIGHT = 3'b000;
   localparam logic [2:0] DIR_UP    = 3'b001;
   localparam logic [2:0] DIR_LEFT  = 3'b010;
   localparam logic [2:0] DIR_DOWN  = 3'b011;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_SPACE = 8'h29;

   typedef logic [1:0] parse_state_t;
   localparam parse_state_t PS_IDLE    = 2'd0;
   localparam parse_state_t PS_EXT     = 2'd1;
   localparam parse_state_t PS_BRK     = 2'd2;
   localparam parse_state_t PS_EXT_BRK = 2'd3;

   // Opposite directions share bit0 and differ only in bit1.
   function automatic logic is_opposite(input logic [2:0] a, input logic [2:0] b);
      return (a ^ b) == 3'b010;
   endfunction

   // Returns {hit, direction}; hit is 0 for non-arrow bytes.
   function automatic logic [3:0] decode_arrow(input logic [7:0] c);
      case (c)
         SC_LEFT:  return {1'b1, DIR_LEFT};
         SC_DOWN:  return {1'b1, DIR_DOWN};
         SC_RIGHT: return {1'b1, DIR_RIGHT};
         SC_UP:    return {1'b1, DIR_UP};
         default:  return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// rtl/snake_dir_ctrl_if.sv - scancode/tick inputs and steering outputs of snake_dir_ctrl
interface snake_dir_ctrl_if;
   logic       code_valid;
   logic [7:0] code;
   logic       tick;
   logic [2:0] dir;
   logic       dir_step;
   logic       paused;
   logic [1:0] q_count;

   modport master (output code_valid, code, tick, input dir, dir_step, paused, q_count);
   modport slave  (input code_valid, code, tick, output dir, dir_step, paused, q_count);
endinterface

// File: rtl/dir_fifo.sv
// rtl/dir_fifo.sv - two-entry direction FIFO accepting push+pop together when full
module dir_fifo (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [2:0] din,
   output logic [2:0] head,
   output logic [2:0] tail,
   output logic [1:0] count
);

   logic [2:0] mem0_q, mem0_d;
   logic [2:0] mem1_q, mem1_d;
   logic [1:0] count_q, count_d;
   logic       pop_ok, push_ok;
   logic [1:0] cnt_mid;

   // Pop shifts entry 1 down first, then the push lands at the post-pop fill level.
   always_comb begin
      pop_ok  = pop && (count_q != 2'd0);
      push_ok = push && ((count_q != 2'd2) || pop_ok);
      cnt_mid = count_q - {1'b0, pop_ok};
      mem0_d  = pop_ok ? mem1_q : mem0_q;
      mem1_d  = mem1_q;
      if (push_ok) begin
         if (cnt_mid == 2'd0) mem0_d = din;
         else                 mem1_d = din;
      end
      count_d = cnt_mid + {1'b0, push_ok};
   end

   // Storage and fill-level registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem0_q  <= 3'b000;
         mem1_q  <= 3'b000;
         count_q <= 2'd0;
      end else begin
         mem0_q  <= mem0_d;
         mem1_q  <= mem1_d;
         count_q <= count_d;
      end
   end

   assign head  = mem0_q;
   assign tail  = (count_q == 2'd2) ? mem1_q : mem0_q;
   assign count = count_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - PS/2 steering parser, turn filter, pause and per-tick turn sequencer
module snake_dir_ctrl
   import snake_pkg::*;
#(
   parameter logic [2:0] INIT_DIR = DIR_RIGHT
) (
   input  logic              clk,
   input  logic              reset,
   snake_dir_ctrl_if.slave   bus
);

   parse_state_t state_q, state_d;
   logic [2:0]   dir_q, dir_d;
   logic         dir_step_q, dir_step_d;
   logic         paused_q, paused_d;
   logic         space_held_q, space_held_d;

   logic         make_ev, brk_ev;
   logic [3:0]   arrow;
   logic [2:0]   ref_dir;
   logic         step_ok, push, space_make, space_brk;
   logic [2:0]   fifo_head, fifo_tail;
   logic [1:0]   fifo_count;

   // Prefix parser: E0 always restarts an extended sequence, F0 arms a break.
   always_comb begin
      state_d = state_q;
      make_ev = 1'b0;
      brk_ev  = 1'b0;
      if (bus.code_valid) begin
         if (bus.code == SC_EXT) begin
            state_d = PS_EXT;
         end else begin
            case (state_q)
               PS_IDLE: begin
                  if (bus.code == SC_BRK) state_d = PS_BRK;
                  else                    make_ev = 1'b1;
               end
               PS_EXT: begin
                  if (bus.code == SC_BRK) begin
                     state_d = PS_EXT_BRK;
                  end else begin
                     make_ev = 1'b1;
                     state_d = PS_IDLE;
                  end
               end
               default: begin
                  brk_ev  = 1'b1;
                  state_d = PS_IDLE;
               end
            endcase
         end
      end
   end

   // Turn filter against the newest pending turn, pause toggling and tick-driven pop.
   always_comb begin
      arrow        = decode_arrow(bus.code);
      step_ok      = bus.tick && !paused_q;
      ref_dir      = (fifo_count != 2'd0) ? fifo_tail : dir_q;
      push         = make_ev && arrow[3] && !paused_q &&
                     (arrow[2:0] != ref_dir) && !is_opposite(arrow[2:0], ref_dir);
      dir_d        = (step_ok && (fifo_count != 2'd0)) ? fifo_head : dir_q;
      dir_step_d   = step_ok;
      space_make   = make_ev && (bus.code == SC_SPACE);
      space_brk    = brk_ev && (bus.code == SC_SPACE);
      paused_d     = paused_q ^ (space_make && !space_held_q);
      space_held_d = space_held_q;
      if (space_make)     space_held_d = 1'b1;
      else if (space_brk) space_held_d = 1'b0;
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= PS_IDLE;
         dir_q        <= INIT_DIR;
         dir_step_q   <= 1'b0;
         paused_q     <= 1'b0;
         space_held_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         dir_step_q   <= dir_step_d;
         paused_q     <= paused_d;
         space_held_q <= space_held_d;
      end
   end

   dir_fifo u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (step_ok),
      .din   (arrow[2:0]),
      .head  (fifo_head),
      .tail  (fifo_tail),
      .count (fifo_count)
   );

   assign bus.dir      = dir_q;
   assign bus.dir_step = dir_step_q;
   assign bus.paused   = paused_q;
   assign bus.q_count  = fifo_count;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb/tb_snake_dir_ctrl.sv - randomized and directed self-checking bench for snake_dir_ctrl
module tb_snake_dir_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   snake_dir_ctrl_if bus();

   snake_dir_ctrl #(.INIT_DIR(3'b000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state: a plain queue of pending turns plus a break-prefix flag.
   int m_dir;
   bit m_step, m_paused, m_held, m_brk, armed;
   int m_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int arrow_of(input logic [7:0] b);
      case (b)
         8'h6B:   return 2;
         8'h72:   return 3;
         8'h74:   return 0;
         8'h75:   return 1;
         default: return -1;
      endcase
   endfunction

   task automatic model_step();
      bit step, mk, bk;
      int cand, rf;
      logic [7:0] b;
      if (reset) begin
         m_dir = 0; m_step = 0; m_paused = 0; m_held = 0; m_brk = 0;
         m_q.delete();
         armed = 1;
         return;
      end
      step = bus.tick && !m_paused;
      mk = 0; bk = 0;
      b = bus.code;
      if (bus.code_valid) begin
         if (b == 8'hE0)      m_brk = 0;
         else if (m_brk)      begin bk = 1; m_brk = 0; end
         else if (b == 8'hF0) m_brk = 1;
         else                 mk = 1;
      end
      cand = arrow_of(b);
      rf = (m_q.size() > 0) ? m_q[$] : m_dir;
      if (step && m_q.size() > 0) m_dir = m_q.pop_front();
      if (mk && cand >= 0 && !m_paused && cand != rf && (cand ^ rf) != 2 && m_q.size() < 2)
         m_q.push_back(cand);
      m_step = step;
      if (mk && b == 8'h29 && !m_held) begin m_paused = !m_paused; m_held = 1; end
      if (bk && b == 8'h29) m_held = 0;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (armed) begin
         check("dir", bus.dir, m_dir);
         check("dir_step", bus.dir_step, m_step);
         check("paused", bus.paused, m_paused);
         check("q_count", bus.q_count, m_q.size());
      end
   end

   task automatic cyc(input bit v, input logic [7:0] b, input bit t, input bit r);
      @(negedge clk);
      bus.code_valid = v;
      bus.code       = b;
      bus.tick       = t;
      reset          = r;
   endtask

   task automatic idle();     cyc(1'b0, 8'h00, 1'b0, 1'b0); endtask
   task automatic key(input logic [7:0] b); cyc(1'b1, b, 1'b0, 1'b0); endtask
   task automatic tick();     cyc(1'b0, 8'h00, 1'b1, 1'b0); endtask
   task automatic do_reset(); cyc(1'b0, 8'h00, 1'b0, 1'b1); idle(); endtask

   logic [7:0] pool [9];

   initial begin
      reset = 1'b1;
      bus.code_valid = 1'b0;
      bus.code = 8'h00;
      bus.tick = 1'b0;
      armed = 0;
      pool = '{8'hE0, 8'hF0, 8'h6B, 8'h72, 8'h74, 8'h75, 8'h29, 8'h00, 8'h00};

      // Reset state and plain ticking.
      do_reset();
      check("rst_dir", bus.dir, 0);
      check("rst_paused", bus.paused, 0);
      check("rst_q", bus.q_count, 0);
      check("rst_step", bus.dir_step, 0);
      for (int i = 0; i < 4; i++) begin
         tick(); idle();
         check("tick_pulse", bus.dir_step, 1);
         check("tick_dir", bus.dir, 0);
      end

      // Extended up arrow then a tick.
      do_reset();
      key(8'hE0); key(8'h75); idle();
      check("ext_up_q", bus.q_count, 1);
      tick(); idle();
      check("ext_up_dir", bus.dir, 1);
      check("ext_up_q0", bus.q_count, 0);

      // Opposite/same rejection and extended break.
      do_reset();
      key(8'h6B); key(8'h74); idle();
      check("reject_q", bus.q_count, 0);
      key(8'hE0); key(8'hF0); key(8'h75); idle();
      check("break_q", bus.q_count, 0);

      // Queue fills at two, third turn discarded.
      do_reset();
      key(8'h75); key(8'h6B); key(8'h72); idle();
      check("full_q", bus.q_count, 2);
      tick(); idle();
      check("pop1_dir", bus.dir, 1);
      tick(); idle();
      check("pop2_dir", bus.dir, 2);
      check("pop2_q", bus.q_count, 0);

      // Pause with typematic repeats, then unpause.
      do_reset();
      key(8'h29); idle();
      check("pause_on", bus.paused, 1);
      key(8'h29); key(8'h29); key(8'h29); key(8'hF0); key(8'h29);
      tick(); idle();
      check("pause_hold", bus.paused, 1);
      check("pause_nostep", bus.dir_step, 0);
      key(8'h29); idle();
      check("pause_off", bus.paused, 0);
      tick(); idle();
      check("pause_resume", bus.dir_step, 1);
      key(8'hF0); key(8'h29);
      cyc(1'b1, 8'h29, 1'b1, 1'b0); idle();
      check("pause_tick_same_step", bus.dir_step, 1);
      check("pause_tick_same_paused", bus.paused, 1);

      // Full queue with simultaneous tick and make; reset clears a pending prefix.
      do_reset();
      key(8'h75); key(8'h6B);
      cyc(1'b1, 8'h72, 1'b1, 1'b0); idle();
      check("pushpop_q", bus.q_count, 2);
      check("pushpop_dir", bus.dir, 1);
      key(8'hE0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      key(8'h75); idle();
      check("rst_prefix_q", bus.q_count, 1);
      check("rst_prefix_dir", bus.dir, 0);
      tick(); idle();
      check("rst_prefix_pop", bus.dir, 1);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         logic [7:0] b;
         b = pool[$urandom_range(0, 8)];
         if (b == 8'h00) b = 8'($urandom);
         cyc($urandom_range(0, 2) == 0, b, $urandom_range(0, 5) == 0,
             $urandom_range(0, 299) == 0);
      end
      idle(); idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
